// File: rtl/rtc_alarm_core.sv
// Time-of-day core: 24 h BCD counters advanced by a 1 Hz enable. It has a 12/24 h display
// map, range-checked time and alarm loads, an auto-timeout alarm FSM and a midnight pulse.
module rtc_alarm_core #(
    parameter int ALARM_LEN = 60,
    parameter int RST_HH    = 0,
    parameter int RST_MM    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       mode_12h,
    input  logic       set_en,
    input  logic [4:0] set_hh,
    input  logic [5:0] set_mm,
    input  logic [5:0] set_ss,
    input  logic       alarm_wr,
    input  logic [4:0] alarm_hh,
    input  logic [5:0] alarm_mm,
    input  logic       alarm_arm,
    input  logic       alarm_ack,
    output logic [3:0] h_tens,
    output logic [3:0] h_ones,
    output logic [3:0] m_tens,
    output logic [3:0] m_ones,
    output logic [3:0] s_tens,
    output logic [3:0] s_ones,
    output logic       pm,
    output logic       alarm_ring,
    output logic       set_err,
    output logic       day_tick
);

    localparam int CNT_W = $clog2(ALARM_LEN + 1);
    localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(ALARM_LEN - 1);
    localparam logic [3:0] RST_HT = 4'(RST_HH / 10);
    localparam logic [3:0] RST_HO = 4'(RST_HH % 10);
    localparam logic [3:0] RST_MT = 4'(RST_MM / 10);
    localparam logic [3:0] RST_MO = 4'(RST_MM % 10);

    // Binary 0..63 to two BCD digits; the ones digit is exact in 4-bit modular arithmetic.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] t;
        if (v >= 6'd60)      t = 4'd6;
        else if (v >= 6'd50) t = 4'd5;
        else if (v >= 6'd40) t = 4'd4;
        else if (v >= 6'd30) t = 4'd3;
        else if (v >= 6'd20) t = 4'd2;
        else if (v >= 6'd10) t = 4'd1;
        else                 t = 4'd0;
        return {t, v[3:0] - (t * 4'd10)};
    endfunction

    typedef enum logic {IDLE, RING} alarm_state_t;

    alarm_state_t     state_reg;
    logic [CNT_W-1:0] ring_cnt_reg;

    // Index 0 = seconds, index 1 = minutes.
    logic [1:0][3:0] ms_tens_reg, ms_ones_reg;
    logic [1:0][3:0] ms_tens_next, ms_ones_next;
    logic [1:0]      at_max, stage_carry, ones_wrap;
    logic [3:0]      h_tens_reg, h_ones_reg, h_tens_next, h_ones_next;
    logic            hour_carry, day_wrap;

    logic [3:0] al_ht_reg, al_ho_reg, al_mt_reg, al_mo_reg;
    logic       set_err_reg, day_tick_reg;

    logic       set_ok, alarm_ok, eff_tick, match, trigger;
    logic [7:0] set_h_bcd, set_m_bcd, set_s_bcd, al_h_bcd, al_m_bcd;

    assign stage_carry = {at_max[0], 1'b1};
    assign hour_carry  = &at_max;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ms
            assign at_max[gi]    = (ms_ones_reg[gi] == 4'd9) && (ms_tens_reg[gi] == 4'd5);
            assign ones_wrap[gi] = stage_carry[gi] && (ms_ones_reg[gi] == 4'd9);
            assign ms_ones_next[gi] = !stage_carry[gi] ? ms_ones_reg[gi] :
                                      ones_wrap[gi]    ? 4'd0 : ms_ones_reg[gi] + 4'd1;
            assign ms_tens_next[gi] = !ones_wrap[gi] ? ms_tens_reg[gi] :
                                      at_max[gi]     ? 4'd0 : ms_tens_reg[gi] + 4'd1;
        end
    endgenerate

    always_comb begin
        h_tens_next = h_tens_reg;
        h_ones_next = h_ones_reg;
        if (hour_carry) begin
            if (h_tens_reg == 4'd2 && h_ones_reg == 4'd3) begin
                h_tens_next = 4'd0;
                h_ones_next = 4'd0;
            end else if (h_ones_reg == 4'd9) begin
                h_tens_next = h_tens_reg + 4'd1;
                h_ones_next = 4'd0;
            end else begin
                h_ones_next = h_ones_reg + 4'd1;
            end
        end
    end

    assign day_wrap = hour_carry && (h_tens_reg == 4'd2) && (h_ones_reg == 4'd3);

    assign set_ok    = (set_hh <= 5'd23) && (set_mm <= 6'd59) && (set_ss <= 6'd59);
    assign alarm_ok  = (alarm_hh <= 5'd23) && (alarm_mm <= 6'd59);
    assign set_h_bcd = to_bcd({1'b0, set_hh});
    assign set_m_bcd = to_bcd(set_mm);
    assign set_s_bcd = to_bcd(set_ss);
    assign al_h_bcd  = to_bcd({1'b0, alarm_hh});
    assign al_m_bcd  = to_bcd(alarm_mm);

    // A load takes the cycle, so a coincident tick neither advances time nor fires the alarm.
    assign eff_tick = tick_1hz && !set_en;
    assign match    = (ms_tens_next[0] == 4'd0) && (ms_ones_next[0] == 4'd0) &&
                      (ms_tens_next[1] == al_mt_reg) && (ms_ones_next[1] == al_mo_reg) &&
                      (h_tens_next == al_ht_reg) && (h_ones_next == al_ho_reg);
    assign trigger  = eff_tick && match && alarm_arm;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_tens_reg   <= RST_HT;
            h_ones_reg   <= RST_HO;
            ms_tens_reg  <= {RST_MT, 4'd0};
            ms_ones_reg  <= {RST_MO, 4'd0};
            al_ht_reg    <= 4'd0;
            al_ho_reg    <= 4'd0;
            al_mt_reg    <= 4'd0;
            al_mo_reg    <= 4'd0;
            set_err_reg  <= 1'b0;
            day_tick_reg <= 1'b0;
            state_reg    <= IDLE;
            ring_cnt_reg <= '0;
        end else begin
            set_err_reg  <= (set_en && !set_ok) || (alarm_wr && !alarm_ok);
            day_tick_reg <= eff_tick && day_wrap;

            if (set_en) begin
                if (set_ok) begin
                    h_tens_reg  <= set_h_bcd[7:4];
                    h_ones_reg  <= set_h_bcd[3:0];
                    ms_tens_reg <= {set_m_bcd[7:4], set_s_bcd[7:4]};
                    ms_ones_reg <= {set_m_bcd[3:0], set_s_bcd[3:0]};
                end
            end else if (tick_1hz) begin
                h_tens_reg  <= h_tens_next;
                h_ones_reg  <= h_ones_next;
                ms_tens_reg <= ms_tens_next;
                ms_ones_reg <= ms_ones_next;
            end

            if (alarm_wr && alarm_ok) begin
                al_ht_reg <= al_h_bcd[7:4];
                al_ho_reg <= al_h_bcd[3:0];
                al_mt_reg <= al_m_bcd[7:4];
                al_mo_reg <= al_m_bcd[3:0];
            end

            case (state_reg)
                IDLE: begin
                    if (trigger && !alarm_ack) begin
                        state_reg    <= RING;
                        ring_cnt_reg <= '0;
                    end
                end
                RING: begin
                    if (alarm_ack || !alarm_arm) begin
                        state_reg <= IDLE;
                    end else if (eff_tick) begin
                        if (ring_cnt_reg == RING_LAST) begin
                            state_reg <= IDLE;
                        end else begin
                            ring_cnt_reg <= ring_cnt_reg + CNT_W'(1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // 12 h display is a pure remap of the stored 24 h hour.
    logic [4:0] hour_bin;
    logic [7:0] disp_h, h_minus_12;

    assign hour_bin   = ({1'b0, h_tens_reg} * 5'd10) + {1'b0, h_ones_reg};
    assign h_minus_12 = to_bcd({1'b0, hour_bin - 5'd12});

    always_comb begin
        disp_h = {h_tens_reg, h_ones_reg};
        pm     = 1'b0;
        if (mode_12h) begin
            pm = (hour_bin >= 5'd12);
            if (hour_bin == 5'd0 || hour_bin == 5'd12) begin
                disp_h = 8'h12;
            end else if (hour_bin > 5'd12) begin
                disp_h = h_minus_12;
            end
        end
    end

    assign h_tens     = disp_h[7:4];
    assign h_ones     = disp_h[3:0];
    assign m_tens     = ms_tens_reg[1];
    assign m_ones     = ms_ones_reg[1];
    assign s_tens     = ms_tens_reg[0];
    assign s_ones     = ms_ones_reg[0];
    assign alarm_ring = (state_reg == RING);
    assign set_err    = set_err_reg;
    assign day_tick   = day_tick_reg;

endmodule

// File: tb/tb_rtc_alarm_core.sv
// Directed bench for rtc_alarm_core with ALARM_LEN=3: rollover, 12 h map, load checks, alarm.
module tb_rtc_alarm_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz, mode_12h, set_en, alarm_wr, alarm_arm, alarm_ack;
    logic [4:0] set_hh, alarm_hh;
    logic [5:0] set_mm, set_ss, alarm_mm;
    logic [3:0] h_tens, h_ones, m_tens, m_ones, s_tens, s_ones;
    logic       pm, alarm_ring, set_err, day_tick;

    int n_cmp = 0;
    int n_bad = 0;

    rtc_alarm_core #(.ALARM_LEN(3), .RST_HH(0), .RST_MM(0)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .mode_12h(mode_12h),
        .set_en(set_en), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
        .alarm_wr(alarm_wr), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
        .alarm_arm(alarm_arm), .alarm_ack(alarm_ack),
        .h_tens(h_tens), .h_ones(h_ones), .m_tens(m_tens), .m_ones(m_ones),
        .s_tens(s_tens), .s_ones(s_ones), .pm(pm), .alarm_ring(alarm_ring),
        .set_err(set_err), .day_tick(day_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] disp();
        return {8'h00, h_tens, h_ones, m_tens, m_ones, s_tens, s_ones};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_set(input int hh, input int mm, input int ss);
        set_hh = 5'(hh); set_mm = 6'(mm); set_ss = 6'(ss);
        set_en = 1'b1;
        step();
        set_en = 1'b0;
        $display("set %0d:%0d:%0d -> %06h err=%0b", hh, mm, ss, disp(), set_err);
    endtask

    task automatic do_tick();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        $display("tick -> %06h ring=%0b day=%0b", disp(), alarm_ring, day_tick);
    endtask

    initial begin
        rst = 1'b1; tick_1hz = 0; mode_12h = 0; set_en = 0; alarm_wr = 0;
        alarm_arm = 0; alarm_ack = 0; set_hh = 0; set_mm = 0; set_ss = 0;
        alarm_hh = 0; alarm_mm = 0;
        step(); step();
        rst = 1'b0;
        $display("reset -> %06h", disp());
        check_eq("rst_disp24", disp(), 32'h000000);
        check_eq("rst_ring", {31'd0, alarm_ring}, 32'd0);
        check_eq("rst_err", {31'd0, set_err}, 32'd0);
        check_eq("rst_day", {31'd0, day_tick}, 32'd0);
        mode_12h = 1'b1; #1;
        check_eq("rst_disp12", disp(), 32'h120000);
        check_eq("rst_pm", {31'd0, pm}, 32'd0);
        mode_12h = 1'b0;

        // Midnight rollover with back-to-back ticks
        do_set(23, 59, 58);
        check_eq("set_235958", disp(), 32'h235958);
        check_eq("set_no_day", {31'd0, day_tick}, 32'd0);
        do_tick();
        check_eq("tick_235959", disp(), 32'h235959);
        check_eq("day_early", {31'd0, day_tick}, 32'd0);
        do_tick();
        check_eq("tick_000000", disp(), 32'h000000);
        check_eq("day_pulse", {31'd0, day_tick}, 32'd1);
        step();
        check_eq("day_clear", {31'd0, day_tick}, 32'd0);

        // 12 h display
        mode_12h = 1'b1;
        do_set(13, 5, 0);
        check_eq("h12_0105", disp(), 32'h010500);
        check_eq("h12_pm13", {31'd0, pm}, 32'd1);
        do_set(23, 45, 12);
        check_eq("h12_1145", disp(), 32'h114512);
        do_set(12, 0, 0);
        check_eq("h12_noon", disp(), 32'h120000);
        check_eq("h12_pm12", {31'd0, pm}, 32'd1);
        do_set(9, 8, 7);
        check_eq("h12_0908", disp(), 32'h090807);
        check_eq("h12_am9", {31'd0, pm}, 32'd0);
        mode_12h = 1'b0; #1;
        check_eq("h24_0908", disp(), 32'h090807);

        // Range checks and set/tick precedence
        do_set(10, 0, 0);
        do_set(10, 60, 0);
        check_eq("err_pulse", {31'd0, set_err}, 32'd1);
        check_eq("err_hold", disp(), 32'h100000);
        step();
        check_eq("err_clear", {31'd0, set_err}, 32'd0);
        tick_1hz = 1'b1;
        do_set(10, 0, 0);
        tick_1hz = 1'b0;
        check_eq("tick_drop", disp(), 32'h100000);
        alarm_hh = 5'd24; alarm_mm = 6'd0; alarm_wr = 1'b1;
        step();
        alarm_wr = 1'b0;
        check_eq("alarm_err", {31'd0, set_err}, 32'd1);

        // Alarm rings and times out after 3 ticks
        alarm_hh = 5'd7; alarm_mm = 6'd30; alarm_wr = 1'b1;
        step();
        alarm_wr = 1'b0;
        check_eq("alarm_wr_ok", {31'd0, set_err}, 32'd0);
        alarm_arm = 1'b1;
        do_set(7, 29, 59);
        check_eq("set_no_ring", {31'd0, alarm_ring}, 32'd0);
        do_tick();
        check_eq("ring_time", disp(), 32'h073000);
        check_eq("ring_on", {31'd0, alarm_ring}, 32'd1);
        do_tick();
        check_eq("ring_t1", {31'd0, alarm_ring}, 32'd1);
        do_tick();
        check_eq("ring_t2", {31'd0, alarm_ring}, 32'd1);
        do_tick();
        check_eq("ring_timeout", {31'd0, alarm_ring}, 32'd0);
        check_eq("time_073003", disp(), 32'h073003);

        // Acknowledge
        do_set(7, 29, 59);
        do_tick();
        check_eq("ring_again", {31'd0, alarm_ring}, 32'd1);
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
        check_eq("ack_clear", {31'd0, alarm_ring}, 32'd0);

        // Disarm stops ringing
        do_set(7, 29, 59);
        do_tick();
        check_eq("ring_arm", {31'd0, alarm_ring}, 32'd1);
        alarm_arm = 1'b0;
        step();
        alarm_arm = 1'b1;
        check_eq("disarm_clear", {31'd0, alarm_ring}, 32'd0);

        // Direct load of the alarm time must not ring
        do_set(7, 30, 0);
        check_eq("load_match", {31'd0, alarm_ring}, 32'd0);
        step();
        check_eq("load_match2", {31'd0, alarm_ring}, 32'd0);

        // Ack coinciding with trigger wins
        do_set(7, 29, 59);
        alarm_ack = 1'b1;
        do_tick();
        alarm_ack = 1'b0;
        check_eq("ack_vs_trig", {31'd0, alarm_ring}, 32'd0);

        // Reset mid-ring
        do_set(7, 29, 59);
        do_tick();
        check_eq("ring_pre_rst", {31'd0, alarm_ring}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rst_ring_off", {31'd0, alarm_ring}, 32'd0);
        check_eq("rst_time", disp(), 32'h000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rtc_alarm_core.md
# rtc_alarm_core

Parametrised successor to the HH:MM:SS clock core. It keeps time-of-day in BCD counters advanced by the 1 Hz enable pulse from `freq_div`. It adds a selectable 12/24-hour display, synchronous time load with range checking, a programmable alarm with auto-timeout and acknowledge, and a midnight rollover pulse. It sits between `freq_div` and the 7-segment/display driver.

## Interface
- `ALARM_LEN`, default 60: seconds (`tick_1hz` pulses) the alarm rings before self-clearing; legal range ≥1.
- `RST_HH`, default 0: hour loaded at reset (0–23, binary).
- `RST_MM`, default 0: minute loaded at reset (0–59).

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `tick_1hz`  in  1  one-cycle enable; advances time by 1 s.
- `mode_12h`  in  1  0 = 24 h display, 1 = 12 h display (level; display only).
- `set_en`  in  1  one-cycle strobe; load `set_hh`/`set_mm`/`set_ss`.
- `set_hh`  in  5  hour, binary.
- `set_mm`  in  6  minute, binary.
- `set_ss`  in  6  second, binary.
- `alarm_wr`  in  1  one-cycle strobe; load `alarm_hh`/`alarm_mm`.
- `alarm_hh`  in  5  alarm hour, binary, 24 h.
- `alarm_mm`  in  6  alarm minute, binary.
- `alarm_arm`  in  1  level; alarm enabled while 1.
- `alarm_ack`  in  1  one-cycle strobe; silences ringing.
- `h_tens`, `h_ones`, `m_tens`, `m_ones`, `s_tens`, `s_ones`  out  4 each  BCD display digits.
- `pm`  out  1  1 when 12 h mode and hour is 12–23; 0 in 24 h mode.
- `alarm_ring`  out  1  alarm active.
- `set_err`  out  1  one-cycle pulse when a `set_en`/`alarm_wr` value is out of range.
- `day_tick`  out  1  one-cycle pulse on the 23:59:59→00:00:00 rollover.

## Operation
- **Time storage.** Internal time is 24 h BCD: six digit registers.
  - Seconds ones wrap 9→0 and carry into seconds tens; seconds tens wrap 5→0 and carry into minutes.
  - Minutes follow the same scheme and carry into hours.
  - Hours go 23→00.
- **Precedence per cycle:** `rst` > `set_en` > `tick_1hz`. A tick coinciding with `set_en` is dropped, and the loaded value is held.
- **Time load (`set_en`):**
  - If `set_hh`≤23, `set_mm`≤59 and `set_ss`≤59, the binary values are converted to BCD and loaded.
  - Otherwise time is unchanged and `set_err` pulses.
  - A load never triggers the alarm and never generates `day_tick`.
- **Alarm write (`alarm_wr`):** loaded if `alarm_hh`≤23 and `alarm_mm`≤59; otherwise `set_err` pulses. `set_err` is the OR of both checks when the strobes coincide.
- **Display mapping:**
  - 24 h mode: digits are the internal registers.
  - 12 h mode: hour 0 → 12 (`pm`=0); hours 1–11 unchanged (`pm`=0); 12 → 12 (`pm`=1); hours 13–23 → hour−12 (`pm`=1).
  - Minutes and seconds are identical in both modes.
  - Display mapping is combinational from state. Toggling `mode_12h` changes the outputs in the same cycle, with no state change.
- **Alarm FSM:**
  - States: IDLE and RING.
  - IDLE→RING: on a tick whose resulting time equals `alarm_hh`:`alarm_mm`:00 while `alarm_arm`=1.
  - RING→IDLE on any of the following:
    - `alarm_ack`=1.
    - `alarm_arm`=0.
    - `ALARM_LEN` ticks counted since entry.
  - Ring counter width is clog2(`ALARM_LEN`+1) and clears on entry.
  - If `alarm_ack` and a trigger occur in the same cycle, ack wins and the FSM stays IDLE.
  - Rewriting the alarm register while in RING does not stop ringing.
- `alarm_ring` = (state == RING).

## Timing
- **Reset:**
  - Time = `RST_HH`:`RST_MM`:00.
  - Alarm register = 00:00.
  - FSM in IDLE with ring counter 0.
  - `alarm_ring`=0, `set_err`=0, `day_tick`=0.
  - With defaults in 24 h mode the digits read 0,0,0,0,0,0. In 12 h mode they read 1,2,0,0,0,0 with `pm`=0.
- **Latency:**
  - The edge sampling `tick_1hz`=1 updates time; new digits are visible immediately after that edge (1-cycle latency from tick).
  - `set_en` has the same 1-cycle latency.
- `day_tick` and the RING entry are registered on the same edge as the rollover or match, so they assert in the cycle where the new time is first visible.
- `set_err` asserts for exactly the cycle after the offending strobe.
- On the `ALARM_LEN`-th tick after entry, `alarm_ring` deasserts on that tick's edge.
- Back-to-back ticks on consecutive cycles are legal and each advances 1 s.
- `rst` asserted mid-ring forces IDLE on the next edge.

## Test plan
- Reset with defaults, 24 h: digits 000000, `alarm_ring`=0. Switch to `mode_12h`=1 → 12:00:00, `pm`=0.
- Set 23:59:58, apply 2 ticks → 23:59:59, then 00:00:00. `day_tick` is high exactly on the second update cycle.
- Set 13:05:00 in 12 h mode → 01:05:00, `pm`=1. Set 12:00:00 → 12:00:00, `pm`=1.
- `set_en` with `set_mm`=60 → `set_err` pulses one cycle and time is unchanged. `set_en` and `tick_1hz` in the same cycle with 10:00:00 → 10:00:00 (tick dropped).
- `ALARM_LEN`=3, alarm 07:30, armed, time 07:29:59, apply 1 tick → `alarm_ring`=1. After 3 further ticks → 0.
- Repeat the alarm case, then assert `alarm_ack` one cycle after ring → cleared next edge. Separately, set 07:30:00 directly → no ring.
